// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch and imem
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] addr;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    modport master (
        output req_valid, addr,
        input  req_ready, resp_valid, resp_data
    );
    modport slave (
        input  req_valid, addr,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch PC, single-outstanding imem fetch, IF/ID register with stall hold and redirect squash
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_unit_if.master          imem,
    input  logic                  PCsrc_E_i,
    input  logic [DATA_WIDTH-1:0] PCTarget_E_i,
    input  logic                  stall_D_i,
    output logic [DATA_WIDTH-1:0] instr_D_o,
    output logic [DATA_WIDTH-1:0] PC_D_o,
    output logic [DATA_WIDTH-1:0] PCPlus4_D_o,
    output logic                  valid_D_o,
    output logic [DATA_WIDTH-1:0] pc_F_o
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;
    state_t                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_id_q;
    logic [DATA_WIDTH-1:0] pcp4_id_q;
    logic                  valid_q;
    logic                  fire_d;
    logic                  deliver_d;
    logic [DATA_WIDTH-1:0] pc_plus4_d;
    logic [DATA_WIDTH-1:0] target_d;
    logic [DATA_WIDTH-1:0] fetched_d;
    assign imem.req_valid = (state_q == REQ);
    assign imem.addr      = pc_q;
    assign pc_F_o         = pc_q;
    assign instr_D_o      = instr_q;
    assign PC_D_o         = pc_id_q;
    assign PCPlus4_D_o    = pcp4_id_q;
    assign valid_D_o      = valid_q;
    // Handshake, delivery and next-PC terms shared by the FSM and the IF/ID register
    always_comb begin
        fire_d     = (state_q == REQ) && imem.req_ready;
        pc_plus4_d = pc_q + DATA_WIDTH'(4);
        target_d   = PCTarget_E_i & ~DATA_WIDTH'(3);
        deliver_d  = !PCsrc_E_i && !stall_D_i &&
                     (((state_q == WAIT) && imem.resp_valid) || (state_q == HOLD));
        fetched_d  = (state_q == HOLD) ? hold_q : imem.resp_data;
    end
    // Fetch FSM: redirect beats everything; DROP keeps waiting for the response still owed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else if (PCsrc_E_i) begin
            pc_q    <= target_d;
            hold_q  <= '0;
            state_q <= (state_q == REQ)  ? (fire_d ? DROP : REQ) :
                       (state_q == HOLD) ? REQ :
                       (imem.resp_valid ? REQ : DROP);
        end else begin
            if (deliver_d)
                pc_q <= pc_plus4_d;
            case (state_q)
                REQ:  if (fire_d) state_q <= WAIT;
                WAIT: if (imem.resp_valid) begin
                          if (stall_D_i) begin
                              hold_q  <= imem.resp_data;
                              state_q <= HOLD;
                          end else begin
                              state_q <= REQ;
                          end
                      end
                HOLD: if (!stall_D_i) state_q <= REQ;
                default: if (imem.resp_valid) state_q <= REQ;
            endcase
        end
    end
    // IF/ID register: squash on redirect, load on delivery, hold on stall, otherwise bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            pc_id_q   <= '0;
            pcp4_id_q <= '0;
        end else if (PCsrc_E_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (deliver_d) begin
            valid_q   <= 1'b1;
            instr_q   <= fetched_d;
            pc_id_q   <= pc_q;
            pcp4_id_q <= pc_plus4_d;
        end else if (!stall_D_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end
endmodule
